// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: overflow counter sizing and Gray/binary
// conversion helpers.
// Both converters accept any pointer width up to GRAY_MAX_W. The caller
// zero-extends its pointer on the way in and truncates the result on the way
// out. Leading zero bits do not change either conversion, so the upper bits of
// the result stay zero.
package fifo_pkg;

  localparam int unsigned GRAY_MAX_W  = 32;
  localparam int unsigned OVF_CNT_W   = 8;
  localparam int unsigned OVF_CNT_MAX = 255;

  // XOR-prefix from the MSB down: b[i] = g[MSB] ^ ... ^ g[i]
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchronizer chain: d -> stg[0] -> ... -> stg[STAGES-1] -> q.
// No logic sits between the stages. An asynchronous active-low reset clears
// every stage. The same module serves both pointer-crossing directions.
// Ports: clk, rst_n (async, active-low), d [WIDTH] (async input), q [WIDTH].
module sync_nff #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/rptr_sync_wlevel.sv
// Write-domain receiver for the async FIFO's Gray read pointer.
// The block synchronizes rptr into wclk and outputs it as wq2_rptr. It
// decodes both pointers to produce a registered, pessimistic fill level
// (wlevel) and an almost-full flag. It also holds an optional overflow
// monitor.
// Configuration macro: RSYNC_LEVEL_OVF_EN. Define it to build the overflow
// monitor (wovf/wovf_cnt). Leave it undefined and both outputs are tied to 0,
// and winc/wfull/wovf_clr are ignored.
// Ports:
//   wclk, wrst_n     write clock, async active-low reset
//   rptr             Gray read pointer from the read domain
//   wptr             Gray write pointer (registered, wclk domain)
//   winc, wfull      write request / registered full flag
//   wovf_clr         synchronous clear for the overflow monitor
//   wq2_rptr         synchronized Gray read pointer
//   wlevel           occupancy 0..2^ADDR_SIZE (may overstate, never understates)
//   walmost_full     wlevel >= AFULL_LEVEL, updates together with wlevel
//   wovf, wovf_cnt   sticky overflow flag, saturating attempt count
module rptr_sync_wlevel
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_LEVEL = (1 << ADDR_SIZE) - 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [ADDR_SIZE:0]   rptr,
  input  logic [ADDR_SIZE:0]   wptr,
  input  logic                 winc,
  input  logic                 wfull,
  input  logic                 wovf_clr,
  output logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 walmost_full,
  output logic                 wovf,
  output logic [7:0]           wovf_cnt
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_LEVEL);

  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq2_rptr)
  );

  logic [PW-1:0] rbin;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_nxt;
  logic          afull_nxt;

  // Modular subtraction handles pointer wrap. The result is not clamped.
  always_comb begin
    rbin      = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
    wbin      = PW'(gray2bin(GRAY_MAX_W'(wptr)));
    level_nxt = wbin - rbin;
    afull_nxt = (level_nxt >= AFULL_V);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wlevel       <= level_nxt;
      walmost_full <= afull_nxt;
    end
  end

`ifdef RSYNC_LEVEL_OVF_EN
  logic ovf_evt;
  assign ovf_evt = winc & wfull;

  // The clear takes effect first, so a clear plus an event in the same
  // cycle restarts the count at 1.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf     <= 1'b0;
      wovf_cnt <= '0;
    end else if (wovf_clr) begin
      wovf     <= ovf_evt;
      wovf_cnt <= ovf_evt ? 8'd1 : 8'd0;
    end else if (ovf_evt) begin
      wovf <= 1'b1;
      if (wovf_cnt != OVF_CNT_W'(OVF_CNT_MAX)) begin
        wovf_cnt <= wovf_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = &{1'b0, winc, wfull, wovf_clr};
  assign wovf     = 1'b0;
  assign wovf_cnt = '0;
`endif

endmodule

// File: tb/tb_rptr_sync_wlevel.sv
module tb_rptr_sync_wlevel;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [4:0] rptr = '0;
  logic [4:0] wptr = '0;
  logic       winc = 1'b0;
  logic       wfull = 1'b0;
  logic       wovf_clr = 1'b0;
  logic [4:0] wq2_rptr;
  logic [4:0] wlevel;
  logic       walmost_full;
  logic       wovf;
  logic [7:0] wovf_cnt;

  rptr_sync_wlevel #(
    .ADDR_SIZE   (4),
    .SYNC_STAGES (2),
    .AFULL_LEVEL (14)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .rptr         (rptr),
    .wptr         (wptr),
    .winc         (winc),
    .wfull        (wfull),
    .wovf_clr     (wovf_clr),
    .wq2_rptr     (wq2_rptr),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .wovf         (wovf),
    .wovf_cnt     (wovf_cnt)
  );

  always #5 wclk = ~wclk;

  int unsigned cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    string       name;
    bit          cq;
    logic [4:0]  q2;
    bit          cl;
    logic [4:0]  lv;
    logic        af;
    bit          co;
    logic        ov;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Expected overflow outputs depend on whether the monitor is built
  function automatic logic eo(input logic v);
`ifdef RSYNC_LEVEL_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  function automatic logic [7:0] ec(input logic [7:0] v);
`ifdef RSYNC_LEVEL_OVF_EN
    return v;
`else
    return 8'd0 & v;
`endif
  endfunction

  task automatic push(input int unsigned at, input string nm,
                      input bit cq, input logic [4:0] q2,
                      input bit cl, input logic [4:0] lv, input logic af,
                      input bit co, input logic ov, input logic [7:0] cnt);
    exp_t e;
    e.at = at; e.name = nm; e.cq = cq; e.q2 = q2; e.cl = cl; e.lv = lv;
    e.af = af; e.co = co; e.ov = ov; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Monitor: at each falling edge, compare every expectation due this cycle
  always @(negedge wclk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cq) begin
        checks++;
        if (wq2_rptr !== e.q2) begin
          failures++;
          $display("FAIL %s.wq2_rptr got=%b exp=%b (cyc %0d)", e.name, wq2_rptr, e.q2, cyc);
        end
      end
      if (e.cl) begin
        checks += 2;
        if (wlevel !== e.lv) begin
          failures++;
          $display("FAIL %s.wlevel got=%0d exp=%0d (cyc %0d)", e.name, wlevel, e.lv, cyc);
        end
        if (walmost_full !== e.af) begin
          failures++;
          $display("FAIL %s.walmost_full got=%b exp=%b (cyc %0d)", e.name, walmost_full, e.af, cyc);
        end
      end
      if (e.co) begin
        checks += 2;
        if (wovf !== e.ov) begin
          failures++;
          $display("FAIL %s.wovf got=%b exp=%b (cyc %0d)", e.name, wovf, e.ov, cyc);
        end
        if (wovf_cnt !== e.cnt) begin
          failures++;
          $display("FAIL %s.wovf_cnt got=%0d exp=%0d (cyc %0d)", e.name, wovf_cnt, e.cnt, cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  initial begin
    int unsigned c;

    // Power-up reset
    step(3);
    c = cyc;
    push(c, "reset", 1, 5'b00000, 1, 5'd0, 1'b0, 1, 1'b0, 8'd0);
    step(1);
    wrst_n = 1'b1;
    step(2);

    // Plain level: rptr=0, wptr gray 00111 (bin 5)
    c = cyc;
    wptr = 5'b00111;
    push(c + 1, "level5", 1, 5'b00000, 1, 5'd5, 1'b0, 1, 1'b0, 8'd0);
    step(3);

    // Synchronizer latency: rptr 00000 -> 00010 (bin 3)
    c = cyc;
    rptr = 5'b00010;
    push(c + 1, "sync_t1", 1, 5'b00000, 1, 5'd5, 1'b0, 0, 1'b0, 8'd0);
    push(c + 2, "sync_t2", 1, 5'b00010, 1, 5'd5, 1'b0, 0, 1'b0, 8'd0);
    push(c + 3, "sync_t3", 0, 5'b00000, 1, 5'd2, 1'b0, 0, 1'b0, 8'd0);
    step(4);

    // Wrap: wptr bin 2, rptr bin 30 -> level 4
    c = cyc;
    wptr = 5'b00011;
    rptr = 5'b10001;
    push(c + 2, "wrap4_q2", 1, 5'b10001, 0, 5'd0, 1'b0, 0, 1'b0, 8'd0);
    push(c + 3, "wrap4", 0, 5'b00000, 1, 5'd4, 1'b0, 0, 1'b0, 8'd0);
    step(4);

    // Full: wptr bin 16, rptr 0 -> level 16, almost full
    c = cyc;
    wptr = 5'b11000;
    rptr = 5'b00000;
    push(c + 3, "full16", 1, 5'b00000, 1, 5'd16, 1'b1, 0, 1'b0, 8'd0);
    step(4);

    // Threshold around AFULL_LEVEL=14 (rptr=0)
    c = cyc;
    wptr = 5'b01011;                    // bin 13
    push(c + 1, "lvl13", 0, 5'b00000, 1, 5'd13, 1'b0, 0, 1'b0, 8'd0);
    step(1);
    wptr = 5'b01001;                    // bin 14
    push(c + 2, "lvl14", 0, 5'b00000, 1, 5'd14, 1'b1, 0, 1'b0, 8'd0);
    step(1);
    wptr = 5'b00000;                    // bin 0
    push(c + 3, "lvl0", 0, 5'b00000, 1, 5'd0, 1'b0, 0, 1'b0, 8'd0);
    step(1);
    wptr = 5'b01001;                    // back to 14
    step(2);

    // Full without a write request is not an event
    c = cyc;
    wfull = 1'b1;
    push(c + 2, "full_noinc", 0, 5'b00000, 1, 5'd14, 1'b1, 1, 1'b0, 8'd0);
    step(2);

    // 300 overflow attempts: counter saturates at 255
    c = cyc;
    winc = 1'b1;
    push(c + 1, "ovf_first", 0, 5'b00000, 0, 5'd0, 1'b0, 1, eo(1'b1), ec(8'd1));
    push(c + 200, "ovf_mid", 0, 5'b00000, 0, 5'd0, 1'b0, 1, eo(1'b1), ec(8'd200));
    push(c + 300, "ovf_sat", 0, 5'b00000, 1, 5'd14, 1'b1, 1, eo(1'b1), ec(8'd255));
    step(300);

    // Clear alone
    c = cyc;
    winc = 1'b0;
    wovf_clr = 1'b1;
    push(c + 1, "clr_only", 0, 5'b00000, 0, 5'd0, 1'b0, 1, 1'b0, 8'd0);
    step(1);

    // Clear together with an event
    winc = 1'b1;
    push(c + 2, "clr_evt", 0, 5'b00000, 0, 5'd0, 1'b0, 1, eo(1'b1), ec(8'd1));
    step(1);

    // Idle: flag and count hold
    winc = 1'b0;
    wovf_clr = 1'b0;
    wfull = 1'b0;
    push(c + 4, "ovf_hold", 0, 5'b00000, 0, 5'd0, 1'b0, 1, eo(1'b1), ec(8'd1));
    step(2);

    // Mid-run reset: in-flight rptr is discarded, outputs clear at once
    c = cyc;
    rptr = 5'b00010;
    step(1);
    c = cyc;
    push(c, "midrst", 1, 5'b00000, 1, 5'd0, 1'b0, 1, 1'b0, 8'd0);
    wrst_n = 1'b0;
    rptr = 5'b00000;
    step(1);
    wrst_n = 1'b1;
    push(c + 1, "post_rst", 1, 5'b00000, 1, 5'd0, 1'b0, 1, 1'b0, 8'd0);
    push(c + 2, "post_rst_lvl", 1, 5'b00000, 1, 5'd14, 1'b1, 1, 1'b0, 8'd0);
    step(2);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      failures += sb.size();
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
